// File: rtl/serial_subtractor.sv
//------------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor: {bout, d} = x - y - bin, LSB first.
//   Optional two's-complement overflow output enabled by SERIAL_SUB_OVF_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CW     = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    c_last = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_xs;
    logic [WIDTH-1:0] r_ys;
    logic [WIDTH-1:0] r_rs;
    logic             r_borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             r_x_msb;
    logic             r_y_msb;
`endif

    logic             w_a;
    logic             w_b;
    logic             w_diff;
    logic             w_borrow_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    // One full-subtractor cell; the result enters at the MSB and shifts right.
    always_comb begin
        w_a          = r_xs[0];
        w_b          = r_ys[0];
        w_diff       = w_a ^ w_b ^ r_borrow;
        w_borrow_nxt = (~w_a & w_b) | (~w_a & r_borrow) | (w_b & r_borrow);
        w_res_nxt    = {w_diff, r_rs[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_xs     <= '0;
            r_ys     <= '0;
            r_rs     <= '0;
            r_borrow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            d        <= '0;
            bout     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_x_msb  <= 1'b0;
            r_y_msb  <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_xs     <= x;
                        r_ys     <= y;
                        r_rs     <= '0;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                        r_x_msb  <= x[WIDTH-1];
                        r_y_msb  <= y[WIDTH-1];
`endif
                    end
                end

                RUN: begin
                    r_xs     <= r_xs >> 1;
                    r_ys     <= r_ys >> 1;
                    r_rs     <= w_res_nxt;
                    r_borrow <= w_borrow_nxt;
                    r_cnt    <= r_cnt + CW'(1);
                    // d/bout keep the previous result until the final bit lands.
                    if (r_cnt == c_last) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                        d       <= w_res_nxt;
                        bout    <= w_borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        ovf     <= (r_x_msb != r_y_msb) && (w_diff != r_x_msb);
`endif
                    end
                end

                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
